// File: rtl/trap_ctrl.sv
// trap_ctrl: writeback-stage trap/MRET/WFI sequencer driving CSR pulses and fetch redirects.
// Optional WFI sleep support is built when TRAP_CTRL_WFI_EN is defined.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic        mret_req,
    input  logic        wfi_req,
    input  logic [2:0]  irq,
    input  logic        irq_wake,
    input  logic [31:0] trap_vector,
    input  logic [31:0] mret_vector,
    input  logic        redirect_ready,
    output logic        traped,
    output logic        mret,
    output logic [31:0] ecp,
    output logic [3:0]  trap_cause,
    output logic        interupt,
    output logic        retired,
    output logic        flush,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
`ifdef TRAP_CTRL_WFI_EN
    typedef enum logic [1:0] {IDLE, REDIRECT, SLEEP} state_t;
`else
    typedef enum logic [1:0] {IDLE, REDIRECT} state_t;
`endif
    state_t      state, next_state;
    logic [31:0] next_pc;
    logic        take, is_irq;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            redirect_pc <= 32'h0;
        end else begin
            state       <= next_state;
            redirect_pc <= next_pc;
        end
    end
    // rst gates the accept path so outputs drop as soon as reset rises
    assign take   = (state == IDLE) && wb_valid && !rst;
    assign is_irq = |irq;
    always_comb begin
        next_state     = state;
        next_pc        = redirect_pc;
        traped         = 1'b0;
        mret           = 1'b0;
        retired        = 1'b0;
        flush          = 1'b0;
        ecp            = 32'h0;
        trap_cause     = 4'h0;
        interupt       = 1'b0;
        redirect_valid = (state == REDIRECT);
        stall          = (state != IDLE);
        if (take) begin
            if (is_irq || exc_valid) begin
                traped     = 1'b1;
                flush      = 1'b1;
                ecp        = wb_pc;
                interupt   = is_irq;
                trap_cause = is_irq ? (irq[2] ? 4'd11 : irq[0] ? 4'd3 : 4'd7) : exc_cause;
                next_pc    = trap_vector;
                next_state = REDIRECT;
            end else if (mret_req) begin
                mret       = 1'b1;
                retired    = 1'b1;
                flush      = 1'b1;
                next_pc    = mret_vector;
                next_state = REDIRECT;
`ifdef TRAP_CTRL_WFI_EN
            end else if (wfi_req) begin
                retired    = 1'b1;
                flush      = 1'b1;
                next_pc    = wb_pc + 32'd4;
                next_state = SLEEP;
`endif
            end else begin
                retired = 1'b1;
            end
        end
        if (state == REDIRECT && redirect_ready) next_state = IDLE;
`ifdef TRAP_CTRL_WFI_EN
        if (state == SLEEP && irq_wake) next_state = REDIRECT;
`endif
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scoreboard bench for trap_ctrl; honours TRAP_CTRL_WFI_EN.
module tb_trap_ctrl;
    logic        clk = 1'b0, rst;
    logic        wb_valid, exc_valid, mret_req, wfi_req, irq_wake, redirect_ready;
    logic [31:0] wb_pc, trap_vector, mret_vector;
    logic [3:0]  exc_cause;
    logic [2:0]  irq;
    logic        traped, mret, interupt, retired, flush, stall, redirect_valid;
    logic [31:0] ecp, redirect_pc;
    logic [3:0]  trap_cause;

    typedef struct packed {
        logic        t, m, r, f, s, rv, i;
        logic [3:0]  c;
        logic [31:0] e, pc;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, idx = 0;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .mret_req(mret_req), .wfi_req(wfi_req), .irq(irq),
        .irq_wake(irq_wake), .trap_vector(trap_vector), .mret_vector(mret_vector),
        .redirect_ready(redirect_ready), .traped(traped), .mret(mret), .ecp(ecp),
        .trap_cause(trap_cause), .interupt(interupt), .retired(retired), .flush(flush),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic t, m, r, f, s, rv, i, input logic [3:0] c,
                                input logic [31:0] e, pc);
        return '{t: t, m: m, r: r, f: f, s: s, rv: rv, i: i, c: c, e: e, pc: pc};
    endfunction

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle on the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a = '{t: traped, m: mret, r: retired, f: flush, s: stall, rv: redirect_valid,
                  i: interupt, c: trap_cause, e: ecp, pc: redirect_pc};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL step%0d: got t=%b m=%b r=%b f=%b s=%b rv=%b i=%b c=%0d ecp=%h rpc=%h want t=%b m=%b r=%b f=%b s=%b rv=%b i=%b c=%0d ecp=%h rpc=%h",
                         idx, a.t, a.m, a.r, a.f, a.s, a.rv, a.i, a.c, a.e, a.pc,
                         e.t, e.m, e.r, e.f, e.s, e.rv, e.i, e.c, e.e, e.pc);
            end
            idx++;
        end
    end

    initial begin
        rst = 1'b1; wb_valid = 1'b1; wb_pc = 32'h10; exc_valid = 1'b0; exc_cause = 4'd0;
        mret_req = 1'b0; wfi_req = 1'b0; irq = 3'b000; irq_wake = 1'b0;
        trap_vector = 32'h0; mret_vector = 32'h0; redirect_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(mk(0,0,0,0,0,0,0,0,32'h0,32'h0));                       // held in reset
        rst = 1'b0; redirect_ready = 1'b1;
        cyc(mk(0,0,1,0,0,0,0,0,32'h0,32'h0));                       // plain retire, ready ignored
        wb_valid = 1'b0; irq = 3'b001; redirect_ready = 1'b0;
        cyc(mk(0,0,0,0,0,0,0,0,32'h0,32'h0));                       // irq waits for valid instr
        wb_valid = 1'b1; irq = 3'b000; exc_valid = 1'b1; exc_cause = 4'd2;
        wb_pc = 32'h100; trap_vector = 32'h80;
        cyc(mk(1,0,0,1,0,0,0,4'd2,32'h100,32'h0));                  // exception accept
        redirect_ready = 1'b1;
        cyc(mk(0,0,0,0,1,1,0,0,32'h0,32'h80));                      // redirect, wb ignored
        irq = 3'b101; wb_pc = 32'h200; trap_vector = 32'h300; redirect_ready = 1'b0;
        cyc(mk(1,0,0,1,0,0,1,4'd11,32'h200,32'h80));                // eip beats exception
        wb_valid = 1'b0; irq = 3'b000; exc_valid = 1'b0; redirect_ready = 1'b1;
        cyc(mk(0,0,0,0,1,1,0,0,32'h0,32'h300));
        wb_valid = 1'b1; irq = 3'b011; wb_pc = 32'h210; trap_vector = 32'h400; redirect_ready = 1'b0;
        cyc(mk(1,0,0,1,0,0,1,4'd3,32'h210,32'h300));                // sip beats tip
        redirect_ready = 1'b1;
        cyc(mk(0,0,0,0,1,1,0,0,32'h0,32'h400));
        irq = 3'b010; wb_pc = 32'h220; trap_vector = 32'h500; redirect_ready = 1'b0;
        cyc(mk(1,0,0,1,0,0,1,4'd7,32'h220,32'h400));                // tip alone
        redirect_ready = 1'b1;
        cyc(mk(0,0,0,0,1,1,0,0,32'h0,32'h500));
        irq = 3'b000; mret_req = 1'b1; mret_vector = 32'h344; wb_pc = 32'h230; redirect_ready = 1'b0;
        cyc(mk(0,1,1,1,0,0,0,0,32'h0,32'h500));                     // mret accept
        mret_req = 1'b0;
        for (int k = 0; k < 3; k++) cyc(mk(0,0,0,0,1,1,0,0,32'h0,32'h344));
        redirect_ready = 1'b1;
        cyc(mk(0,0,0,0,1,1,0,0,32'h0,32'h344));                     // 4th redirect cycle
        wb_valid = 1'b0; redirect_ready = 1'b0;
        cyc(mk(0,0,0,0,0,0,0,0,32'h0,32'h344));                     // back in idle
        wb_valid = 1'b1; exc_valid = 1'b1; mret_req = 1'b1; exc_cause = 4'd5;
        wb_pc = 32'h240; trap_vector = 32'h600;
        cyc(mk(1,0,0,1,0,0,0,4'd5,32'h240,32'h344));                // exception beats mret
        exc_valid = 1'b0; mret_req = 1'b0;
        cyc(mk(0,0,0,0,1,1,0,0,32'h0,32'h600));
        rst = 1'b1;
        cyc(mk(0,0,0,0,0,0,0,0,32'h0,32'h0));                       // async reset mid-redirect
        rst = 1'b0; wb_pc = 32'h250;
        cyc(mk(0,0,1,0,0,0,0,0,32'h0,32'h0));
        wfi_req = 1'b1; wb_pc = 32'h40;
`ifdef TRAP_CTRL_WFI_EN
        cyc(mk(0,0,1,1,0,0,0,0,32'h0,32'h0));                       // wfi accept
        wfi_req = 1'b0; wb_pc = 32'h50;
        for (int k = 0; k < 5; k++) cyc(mk(0,0,0,0,1,0,0,0,32'h0,32'h44));
        irq_wake = 1'b1;
        cyc(mk(0,0,0,0,1,0,0,0,32'h0,32'h44));
        irq_wake = 1'b0; redirect_ready = 1'b1;
        cyc(mk(0,0,0,0,1,1,0,0,32'h0,32'h44));
        redirect_ready = 1'b0;
        cyc(mk(0,0,1,0,0,0,0,0,32'h0,32'h44));
`else
        cyc(mk(0,0,1,0,0,0,0,0,32'h0,32'h0));                       // wfi is plain retire
        wfi_req = 1'b0; wb_valid = 1'b0; irq_wake = 1'b1;
        for (int k = 0; k < 2; k++) cyc(mk(0,0,0,0,0,0,0,0,32'h0,32'h0));
`endif
        for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
